// File: rtl/in_bitdemux64.sv
// ---------------------------------------------------------------------------
// in_bitdemux64
//
// Purpose:
//   Pulls a programmed number of words out of a source FIFO and spreads them
//   over PEBLKROW_NUM output lanes in bursts of BURST_LEN consecutive words
//   per lane. The lane pointer wraps back to lane 0 after the last lane.
//   Every word goes through three states: FETCH (read strobe), WAIT (capture
//   the FIFO data) and SEND (deliver once the target lane is ready). A DONE
//   state follows the last delivery.
//
// Ports:
//   clk         in   single rising-edge clock
//   reset       in   synchronous, active-high reset
//   start       in   one-cycle pulse that begins a transfer (IDLE only)
//   cfg_words   in   [15:0] number of words to move, sampled with start
//   fifo_empty  in   source FIFO empty flag
//   fifo_rd_en  out  source FIFO read strobe (data valid one cycle later)
//   fifo_dout   in   [TBITS-1:0] source FIFO read data
//   row_ready   in   [PEBLKROW_NUM-1:0] per-lane accept flags
//   valid_dout  out  [PEBLKROW_NUM-1:0] one-hot (or zero) delivery strobe
//   data_dout   out  [PEBLKROW_NUM*TBITS-1:0] per-lane data, lane i at
//                    bits [(i+1)*TBITS-1 -: TBITS]
//   busy        out  high from the cycle after an accepted start up to and
//                    including the done cycle
//   done        out  one-cycle completion pulse
//
// Output timing:
//   valid_dout, data_dout, busy and done are registered. A delivery accepted
//   in SEND shows up on valid_dout/data_dout in the following cycle, together
//   with the freshly written lane, so a consumer always sees strobe and data
//   aligned. done follows one cycle after the last delivery strobe.
//   fifo_rd_en is decoded from the state register and fifo_empty because the
//   FIFO read must happen in the FETCH cycle itself.
// ---------------------------------------------------------------------------
module in_bitdemux64 #(
  parameter int TBITS        = 64,
  parameter int PEBLKROW_NUM = 8,
  parameter int BURST_LEN    = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  input  logic [15:0]                     cfg_words,
  input  logic                            fifo_empty,
  output logic                            fifo_rd_en,
  input  logic [TBITS-1:0]                fifo_dout,
  input  logic [PEBLKROW_NUM-1:0]         row_ready,
  output logic [PEBLKROW_NUM-1:0]         valid_dout,
  output logic [PEBLKROW_NUM*TBITS-1:0]   data_dout,
  output logic                            busy,
  output logic                            done
);

  // Counter widths; a degenerate single-row or single-word burst still gets
  // a one-bit counter so the logic stays uniform.
  localparam int RW = (PEBLKROW_NUM > 1) ? $clog2(PEBLKROW_NUM) : 1;
  localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  localparam logic [RW-1:0] ROW_LAST   = RW'(PEBLKROW_NUM - 1);
  localparam logic [BW-1:0] BURST_LAST = BW'(BURST_LEN - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    WAIT  = 3'd2,
    SEND  = 3'd3,
    DONE  = 3'd4
  } state_e;

  state_e                          state_q,  state_d;
  logic [15:0]                     words_q,  words_d;
  logic [15:0]                     sent_q,   sent_d;
  logic [BW-1:0]                   burst_q,  burst_d;
  logic [RW-1:0]                   row_q,    row_d;
  logic [TBITS-1:0]                hold_q,   hold_d;
  logic [PEBLKROW_NUM-1:0]         valid_q,  valid_d;
  logic [PEBLKROW_NUM*TBITS-1:0]   data_q,   data_d;
  logic                            busy_q,   busy_d;
  logic                            done_q,   done_d;

  logic                            rd_en_s;
  logic [15:0]                     sent_inc_s;

  assign sent_inc_s = sent_q + 16'd1;

  // Next-state, counter and output-register logic for the transfer FSM.
  always_comb begin
    state_d = state_q;
    words_d = words_q;
    sent_d  = sent_q;
    burst_d = burst_q;
    row_d   = row_q;
    hold_d  = hold_q;
    valid_d = '0;
    data_d  = data_q;
    rd_en_s = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (cfg_words != 16'd0) begin
            words_d = cfg_words;
            sent_d  = 16'd0;
            burst_d = '0;
            row_d   = '0;
            state_d = FETCH;
          end else begin
            // Nothing to move: report completion straight away.
            state_d = DONE;
          end
        end else begin
          state_d = IDLE;
        end
      end

      FETCH: begin
        if (!fifo_empty) begin
          rd_en_s = 1'b1;
          state_d = WAIT;
        end else begin
          state_d = FETCH;
        end
      end

      WAIT: begin
        hold_d  = fifo_dout;
        state_d = SEND;
      end

      SEND: begin
        if (row_ready[row_q]) begin
          valid_d[row_q]                = 1'b1;
          data_d[row_q*TBITS +: TBITS]  = hold_q;
          sent_d                        = sent_inc_s;

          // Burst bookkeeping; the last word of a burst on the last row
          // wraps the row pointer in the same update.
          if (burst_q == BURST_LAST) begin
            burst_d = '0;
            if (row_q == ROW_LAST) begin
              row_d = '0;
            end else begin
              row_d = row_q + RW'(1);
            end
          end else begin
            burst_d = burst_q + BW'(1);
          end

          if (sent_inc_s == words_q) begin
            state_d = DONE;
          end else begin
            state_d = FETCH;
          end
        end else begin
          state_d = SEND;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // done is registered from the DONE state so it trails the last strobe.
    if (state_q == DONE) begin
      done_d = 1'b1;
    end else begin
      done_d = 1'b0;
    end

    // busy covers every active state and also the cycle in which done shows.
    if ((state_d != IDLE) || (state_q == DONE)) begin
      busy_d = 1'b1;
    end else begin
      busy_d = 1'b0;
    end
  end

  // State and datapath registers with synchronous reset; reset drops any
  // in-flight word and never produces a done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      words_q <= 16'd0;
      sent_q  <= 16'd0;
      burst_q <= '0;
      row_q   <= '0;
      hold_q  <= '0;
      valid_q <= '0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      words_q <= words_d;
      sent_q  <= sent_d;
      burst_q <= burst_d;
      row_q   <= row_d;
      hold_q  <= hold_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign fifo_rd_en = rd_en_s;
  assign valid_dout = valid_q;
  assign data_dout  = data_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_in_bitdemux64.sv
module tb_in_bitdemux64;

  localparam int TBITS = 64;
  localparam int ROWS  = 8;
  localparam int BL    = 4;

  logic                    clk = 1'b0;
  logic                    reset;
  logic                    start;
  logic [15:0]             cfg_words;
  logic                    fifo_empty = 1'b1;
  logic                    fifo_rd_en;
  logic [TBITS-1:0]        fifo_dout = '0;
  logic [ROWS-1:0]         row_ready;
  logic [ROWS-1:0]         valid_dout;
  logic [ROWS*TBITS-1:0]   data_dout;
  logic                    busy;
  logic                    done;

  always #5 clk = ~clk;

  in_bitdemux64 #(.TBITS(TBITS), .PEBLKROW_NUM(ROWS), .BURST_LEN(BL)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .cfg_words  (cfg_words),
    .fifo_empty (fifo_empty),
    .fifo_rd_en (fifo_rd_en),
    .fifo_dout  (fifo_dout),
    .row_ready  (row_ready),
    .valid_dout (valid_dout),
    .data_dout  (data_dout),
    .busy       (busy),
    .done       (done)
  );

  typedef struct {
    int          row;
    logic [63:0] data;
  } exp_t;

  exp_t        exp_q[$];
  logic [63:0] src_q[$];

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int valid_cnt = 0;
  int done_cnt = 0;
  int rd_cnt = 0;
  int last_valid_cyc = 0;
  int done_cyc = 0;
  int start_cyc = 0;
  logic done_busy = 1'b0;
  logic [ROWS*TBITS-1:0] shadow = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic chk_wide(input string name, input logic [ROWS*TBITS-1:0] act,
                          input logic [ROWS*TBITS-1:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Source FIFO model: data appears one cycle after the read strobe.
  initial begin : fifo_model
    forever begin
      @(posedge clk);
      if (fifo_rd_en && (src_q.size() != 0)) fifo_dout <= src_q.pop_front();
      #2;
      fifo_empty = (src_q.size() == 0);
    end
  end

  // Monitor: pops the scoreboard on every delivery strobe.
  initial begin : monitor
    logic rst_prev;
    exp_t e;
    logic [ROWS-1:0] one;
    rst_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_prev) begin
        shadow = '0;
        chk("rst_valid", 64'(valid_dout), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_rd_en", 64'(fifo_rd_en), 64'd0);
        chk_wide("rst_data", data_dout, '0);
      end else begin
        if (fifo_rd_en) begin
          rd_cnt++;
          chk("rd_en_while_empty", 64'(fifo_empty), 64'd0);
        end
        if (valid_dout != '0) begin
          valid_cnt++;
          last_valid_cyc = cyc;
          chk("valid_onehot", 64'($onehot(valid_dout)), 64'd1);
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_delivery: got valid %0h, expected none", valid_dout);
          end else begin
            e = exp_q.pop_front();
            one = ROWS'(1) << e.row;
            chk("valid_row", 64'(valid_dout), 64'(one));
            chk("lane_data", data_dout[e.row*TBITS +: TBITS], e.data);
            shadow[e.row*TBITS +: TBITS] = e.data;
          end
        end
        chk_wide("lanes_hold", data_dout, shadow);
        if (done) begin
          done_cnt++;
          done_cyc = cyc;
          done_busy = busy;
        end
      end
      rst_prev = reset;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Queue n source words and the matching expected deliveries.
  task automatic load(input int n, input logic [63:0] base);
    for (int k = 0; k < n; k++) begin
      src_q.push_back(base + 64'(k));
      exp_q.push_back('{row: (k / BL) % ROWS, data: base + 64'(k)});
    end
  endtask

  task automatic do_start(input logic [15:0] c);
    start = 1'b1;
    cfg_words = c;
    tick();
    start = 1'b0;
    cfg_words = 16'd0;
    start_cyc = cyc;
  endtask

  task automatic wait_done(input int d0, input int budget, input string name);
    int n;
    n = 0;
    while ((done_cnt == d0) && (n < budget)) begin
      tick();
      n++;
    end
    tests++;
    if (done_cnt == d0) begin
      fails++;
      $display("FAIL %s_timeout: got no done, expected done within %0d cycles", name, budget);
    end
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got no finish, expected finish before 500000 time units");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int v0;
    int d0;
    int r0;
    int n;
    reset = 1'b1;
    start = 1'b0;
    cfg_words = 16'd0;
    row_ready = '1;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    // Reset state
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_valid", 64'(valid_dout), 64'd0);
    chk("reset_rd_en", 64'(fifo_rd_en), 64'd0);
    chk_wide("reset_data", data_dout, '0);

    // Basic: 8 words, rows 0 then 1, 3 cycles per word, done one cycle later
    v0 = valid_cnt; d0 = done_cnt;
    load(8, 64'h1111_0000_0000_0000);
    do_start(16'd8);
    wait_done(d0, 100, "basic");
    chk("basic_pulses", 64'(valid_cnt - v0), 64'd8);
    chk("basic_latency", 64'(last_valid_cyc - start_cyc), 64'd24);
    chk("basic_done_gap", 64'(done_cyc - last_valid_cyc), 64'd1);
    chk("basic_busy_at_done", 64'(done_busy), 64'd1);
    chk("basic_busy_after", 64'(busy), 64'd0);
    chk("basic_sb_empty", 64'(exp_q.size()), 64'd0);

    // Wrap: 36 words cover rows 0..7 and return to row 0
    v0 = valid_cnt; d0 = done_cnt;
    load(36, 64'h2222_0000_0000_0000);
    do_start(16'd36);
    wait_done(d0, 300, "wrap");
    chk("wrap_pulses", 64'(valid_cnt - v0), 64'd36);
    chk("wrap_latency", 64'(last_valid_cyc - start_cyc), 64'd108);
    chk("wrap_sb_empty", 64'(exp_q.size()), 64'd0);

    // Back-pressure on row 0 for 10 SEND cycles
    v0 = valid_cnt; d0 = done_cnt;
    row_ready = 8'hFE;
    load(2, 64'h3333_0000_0000_0000);
    do_start(16'd2);
    tick();
    tick();
    for (int i = 0; i < 10; i++) begin
      chk("bp_valid", 64'(valid_dout), 64'd0);
      chk("bp_rd_en", 64'(fifo_rd_en), 64'd0);
      tick();
    end
    row_ready = '1;
    tick();
    chk("bp_deliver", 64'(valid_dout), 64'h01);
    chk("bp_data", data_dout[TBITS-1:0], 64'h3333_0000_0000_0000);
    wait_done(d0, 50, "bp");
    chk("bp_pulses", 64'(valid_cnt - v0), 64'd2);

    // Empty FIFO stalls in FETCH, then resumes
    v0 = valid_cnt; d0 = done_cnt; r0 = rd_cnt;
    do_start(16'd3);
    for (int i = 0; i < 6; i++) begin
      chk("empty_rd_en", 64'(fifo_rd_en), 64'd0);
      chk("empty_busy", 64'(busy), 64'd1);
      tick();
    end
    chk("empty_no_reads", 64'(rd_cnt - r0), 64'd0);
    load(3, 64'h4444_0000_0000_0000);
    wait_done(d0, 50, "empty");
    chk("empty_pulses", 64'(valid_cnt - v0), 64'd3);
    chk("empty_reads", 64'(rd_cnt - r0), 64'd3);

    // Zero length: done one cycle after the start edge, no reads
    v0 = valid_cnt; d0 = done_cnt; r0 = rd_cnt;
    do_start(16'd0);
    wait_done(d0, 10, "zero");
    chk("zero_done_latency", 64'(done_cyc - start_cyc), 64'd1);
    chk("zero_reads", 64'(rd_cnt - r0), 64'd0);
    chk("zero_pulses", 64'(valid_cnt - v0), 64'd0);

    // Start while busy is ignored
    v0 = valid_cnt; d0 = done_cnt;
    load(4, 64'h5555_0000_0000_0000);
    do_start(16'd4);
    repeat (4) tick();
    start = 1'b1;
    cfg_words = 16'd100;
    tick();
    start = 1'b0;
    cfg_words = 16'd0;
    wait_done(d0, 50, "ign");
    repeat (5) tick();
    chk("ign_pulses", 64'(valid_cnt - v0), 64'd4);
    chk("ign_latency", 64'(last_valid_cyc - start_cyc), 64'd12);
    chk("ign_done_count", 64'(done_cnt - d0), 64'd1);
    chk("ign_idle_busy", 64'(busy), 64'd0);

    // Reset after 3 of 8 deliveries, then restart at row 0
    v0 = valid_cnt; d0 = done_cnt;
    load(8, 64'h6666_0000_0000_0000);
    do_start(16'd8);
    n = 0;
    while ((valid_cnt - v0 < 3) && (n < 50)) begin
      tick();
      n++;
    end
    chk("rst_mid_reached", 64'(valid_cnt - v0), 64'd3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    src_q.delete();
    exp_q.delete();
    repeat (10) tick();
    chk("rst_mid_no_done", 64'(done_cnt - d0), 64'd0);
    chk("rst_mid_pulses", 64'(valid_cnt - v0), 64'd3);
    v0 = valid_cnt; d0 = done_cnt;
    load(2, 64'h7777_0000_0000_0000);
    do_start(16'd2);
    wait_done(d0, 50, "restart");
    chk("restart_pulses", 64'(valid_cnt - v0), 64'd2);
    chk("restart_row0", data_dout[TBITS-1:0], 64'h7777_0000_0000_0001);

    repeat (3) tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
